// File: rtl/icache_pkg.sv
// icache_pkg: shared types and derived address-field widths for icache_sa.
// Holds the controller state enum and OFF/IDX/TAG width helpers.
package icache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        REFILL,
        RESP
    } state_t;

    // Byte-offset bits of a line (word select plus the 2 byte bits).
    function automatic int off_w(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int idx_w(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_w(input int num_sets, input int line_words);
        return 32 - idx_w(num_sets) - off_w(line_words);
    endfunction

endpackage

// File: rtl/icache_plru.sv
// icache_plru: tree pseudo-LRU for one set (combinational).
// Ports: bits (current tree), access_way -> bits_next; victim from bits.
module icache_plru #(
    parameter int NUM_WAYS = 4
) (
    input  logic [NUM_WAYS-2:0]         bits,
    input  logic [$clog2(NUM_WAYS)-1:0] access_way,
    output logic [NUM_WAYS-2:0]         bits_next,
    output logic [$clog2(NUM_WAYS)-1:0] victim
);
    localparam int WW = $clog2(NUM_WAYS);

    // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right).
    // Accessing a way points every node on its path at the other subtree.
    always_comb begin
        int   node;
        logic b;
        bits_next = bits;
        node = 0;
        b = 1'b0;
        for (int l = 0; l < WW; l++) begin
            b = access_way[WW-1-l];
            for (int n = 0; n < NUM_WAYS - 1; n++) begin
                if (n == node) bits_next[n] = ~b;
            end
            node = 2 * node + 1 + (b ? 1 : 0);
        end
    end

    always_comb begin
        int   node;
        logic dir;
        victim = '0;
        node = 0;
        dir = 1'b0;
        for (int l = 0; l < WW; l++) begin
            dir = 1'b0;
            for (int n = 0; n < NUM_WAYS - 1; n++) begin
                if (n == node) dir = bits[n];
            end
            victim[WW-1-l] = dir;
            node = 2 * node + 1 + (dir ? 1 : 0);
        end
    end

endmodule

// File: rtl/icache_sa.sv
// icache_sa: set-associative I-cache, burst line refill, tree PLRU, flush.
// Ports: CPU req/resp, memory line-fill req/beat interface; optional
// perf_hits/perf_misses when ICACHE_PERF_CNT_EN is defined.
module icache_sa
    import icache_pkg::*;
#(
    parameter int NUM_SETS   = 64,
    parameter int NUM_WAYS   = 4,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    input  logic        flush,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        hit,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0] perf_hits,
    output logic [31:0] perf_misses
`endif
);
    localparam int OFF = off_w(LINE_WORDS);
    localparam int IDX = idx_w(NUM_SETS);
    localparam int TAG = tag_w(NUM_SETS, LINE_WORDS);
    localparam int WW  = $clog2(NUM_WAYS);
    localparam int BW  = $clog2(LINE_WORDS);
    localparam logic [BW-1:0] LAST = BW'(LINE_WORDS - 1);

    logic [31:0]    data_q  [NUM_SETS][NUM_WAYS][LINE_WORDS];
    logic [TAG-1:0] tag_q   [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-2:0] plru_q  [NUM_SETS];

    state_t         state_q, state_d;
    logic [31:2]    addr_q;
    logic [WW-1:0]  victim_q;
    logic [BW-1:0]  beat_q;
    logic [31:0]    hold_q;

    logic [IDX-1:0] idx;
    logic [TAG-1:0] tag;
    logic [BW-1:0]  word;
    logic [NUM_WAYS-1:0] hit_vec;
    logic [WW-1:0]  hit_way, inv_way, plru_victim, victim, access_way;
    logic           any_hit, any_inv, last_beat;
    logic [NUM_WAYS-2:0] plru_next;
    logic           unused_addr;

    assign unused_addr = ^req_addr[1:0];
    assign idx  = addr_q[OFF+IDX-1:OFF];
    assign tag  = addr_q[31:OFF+IDX];
    assign word = addr_q[OFF-1:2];
    assign mem_req_addr = {addr_q[31:OFF], {OFF{1'b0}}};
    assign last_beat = mem_resp_valid && (beat_q == LAST);

    // Lowest index wins for both the hit and the free-way encoders.
    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        inv_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            hit_vec[w] = valid_q[idx][w] && (tag_q[idx][w] == tag);
            if (hit_vec[w]) hit_way = WW'(w);
            if (!valid_q[idx][w]) inv_way = WW'(w);
        end
    end

    assign any_hit = |hit_vec;
    assign any_inv = ~&valid_q[idx];
    assign victim = any_inv ? inv_way : plru_victim;
    assign access_way = (state_q == LOOKUP) ? hit_way : victim_q;

    icache_plru #(.NUM_WAYS(NUM_WAYS)) u_plru (
        .bits       (plru_q[idx]),
        .access_way (access_way),
        .bits_next  (plru_next),
        .victim     (plru_victim)
    );

    always_comb begin
        state_d       = state_q;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        hit           = 1'b0;
        resp_data     = '0;
        mem_req_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (!flush && req_valid) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (any_hit) begin
                    resp_valid = 1'b1;
                    hit        = 1'b1;
                    resp_data  = data_q[idx][hit_way][word];
                    state_d    = IDLE;
                end else begin
                    state_d = MISS_REQ;
                end
            end
            MISS_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_d = REFILL;
            end
            REFILL: begin
                if (last_beat) state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_data  = hold_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            victim_q <= '0;
            beat_q   <= '0;
            hold_q   <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                if (flush) begin
                    for (int s = 0; s < NUM_SETS; s++) begin
                        valid_q[s] <= '0;
                        plru_q[s]  <= '0;
                    end
                end else if (req_valid) begin
                    addr_q <= req_addr[31:2];
                end
            end
            if (state_q == LOOKUP) begin
                if (any_hit) plru_q[idx] <= plru_next;
                else victim_q <= victim;
            end
            if (state_q == REFILL && mem_resp_valid) begin
                beat_q <= beat_q + 1'b1;
                if (beat_q == word) hold_q <= mem_resp_data;
                if (beat_q == LAST) begin
                    valid_q[idx][victim_q] <= 1'b1;
                    plru_q[idx] <= plru_next;
                end
            end
        end
    end

    // Line storage needs no reset: valid bits gate every read.
    always_ff @(posedge clk) begin
        if (state_q == REFILL && mem_resp_valid) begin
            data_q[idx][victim_q][beat_q] <= mem_resp_data;
            if (beat_q == LAST) tag_q[idx][victim_q] <= tag;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_hits   <= '0;
            perf_misses <= '0;
        end else if (state_q == LOOKUP) begin
            if (any_hit && perf_hits != '1) perf_hits <= perf_hits + 1;
            if (!any_hit && perf_misses != '1) perf_misses <= perf_misses + 1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_sa.sv
// tb_icache_sa: scoreboard bench for icache_sa with a behavioural memory.
// Default geometry: 64 sets, 4 ways, 4 words/line (set stride 0x400).
module tb_icache_sa;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        req_ready;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        hit;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready = 1'b0;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] perf_hits, perf_misses;
`endif

    icache_sa dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .flush(flush),
        .resp_valid(resp_valid), .resp_data(resp_data), .hit(hit),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
`ifdef ICACHE_PERF_CNT_EN
        , .perf_hits(perf_hits), .perf_misses(perf_misses)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        hit;
    } exp_t;

    exp_t exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    int ready_delay = 0;
    int beat_gap = 0;
    int stable_err = 0;
    int req_count = 0;
    int beat_idx = -1;
    logic [31:0] req_log = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if ({a[31:4], 4'h0} == 32'h1000) return 32'hA0 + 32'(a[3:2]);
        return {a[31:2], 2'b00} ^ 32'h5EED_0000;
    endfunction

    // Memory model: waits ready_delay cycles, then streams 4 beats.
    initial begin
        logic [31:0] a0;
        forever begin
            @(negedge clk);
            if (reset && mem_req_valid) begin
                a0 = mem_req_addr;
                for (int k = 0; k < ready_delay; k++) begin
                    @(negedge clk);
                    if (mem_req_valid !== 1'b1 || mem_req_addr !== a0)
                        stable_err++;
                end
                mem_req_ready = 1'b1;
                req_count++;
                req_log = a0;
                @(negedge clk);
                mem_req_ready = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    for (int g = 0; g < beat_gap; g++) @(negedge clk);
                    if (!reset) break;
                    mem_resp_valid = 1'b1;
                    mem_resp_data = mem_word(a0 + 32'(4 * i));
                    beat_idx = i;
                    @(negedge clk);
                    mem_resp_valid = 1'b0;
                end
                beat_idx = -1;
            end
        end
    end

    task automatic fetch(input logic [31:0] a, output logic [31:0] d,
                         output logic h, output int lat,
                         output bit saw_mem, output bit tout);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr = a;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        saw_mem = 1'b0;
        tout = 1'b1;
        d = '0;
        h = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (mem_req_valid) saw_mem = 1'b1;
            if (resp_valid) begin
                d = resp_data;
                h = hit;
                tout = 1'b0;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({req_ready, resp_valid, hit, resp_data, mem_req_valid,
             mem_req_addr} !== {3'b100, 32'h0, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL reset_values: got rdy=%b rv=%b hit=%b d=%h mv=%b ma=%h want 1 0 0 0 0 0",
                     req_ready, resp_valid, hit, resp_data, mem_req_valid,
                     mem_req_addr);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cold_miss();
        logic [31:0] d; logic h; int lat; bit sm, to; exp_t e; int rc;
        rc = req_count;
        exp_q.push_back('{32'hA1, 1'b0});
        fetch(32'h1004, d, h, lat, sm, to);
        e = exp_q.pop_front();
        n_vec++;
        if (to) begin n_err++; $display("FAIL cold_timeout: no resp within bound"); end
        n_vec++;
        if (d !== e.data) begin n_err++; $display("FAIL cold_data: got %h want %h", d, e.data); end
        n_vec++;
        if (h !== e.hit) begin n_err++; $display("FAIL cold_hit: got %b want %b", h, e.hit); end
        n_vec++;
        if (req_log !== 32'h1000) begin n_err++; $display("FAIL cold_memaddr: got %h want 00001000", req_log); end
        n_vec++;
        if (req_count - rc !== 1) begin n_err++; $display("FAIL cold_reqs: got %0d want 1", req_count - rc); end
        n_vec++;
        if (lat !== 7) begin n_err++; $display("FAIL cold_latency: got %0d want 7", lat); end
    endtask

    task automatic test_hit();
        logic [31:0] d; logic h; int lat; bit sm, to; exp_t e;
        exp_q.push_back('{32'hA2, 1'b1});
        fetch(32'h1008, d, h, lat, sm, to);
        e = exp_q.pop_front();
        n_vec++;
        if (to || d !== e.data) begin n_err++; $display("FAIL hit_data: got %h want %h", d, e.data); end
        n_vec++;
        if (h !== e.hit) begin n_err++; $display("FAIL hit_flag: got %b want %b", h, e.hit); end
        n_vec++;
        if (lat !== 1) begin n_err++; $display("FAIL hit_latency: got %0d want 1", lat); end
        n_vec++;
        if (sm !== 1'b0) begin n_err++; $display("FAIL hit_memreq: got %b want 0", sm); end
`ifdef ICACHE_PERF_CNT_EN
        n_vec++;
        if (perf_hits !== 32'd1 || perf_misses !== 32'd1) begin
            n_err++;
            $display("FAIL perf_counts: got h=%0d m=%0d want 1 1", perf_hits, perf_misses);
        end
`endif
    endtask

    task automatic test_back_to_back();
        exp_t e;
        exp_q.push_back('{32'hA3, 1'b1});
        exp_q.push_back('{32'hA0, 1'b1});
        @(negedge clk);
        req_valid = 1'b1;
        req_addr = 32'h100C;
        @(negedge clk);
        e = exp_q.pop_front();
        n_vec++;
        if (resp_valid !== 1'b1 || resp_data !== e.data || hit !== e.hit) begin
            n_err++;
            $display("FAIL b2b_first: got v=%b d=%h h=%b want 1 %h %b", resp_valid, resp_data, hit, e.data, e.hit);
        end
        req_addr = 32'h1000;
        @(negedge clk);
        n_vec++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_gap: got v=%b rdy=%b want 0 1", resp_valid, req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        e = exp_q.pop_front();
        n_vec++;
        if (resp_valid !== 1'b1 || resp_data !== e.data || hit !== e.hit) begin
            n_err++;
            $display("FAIL b2b_second: got v=%b d=%h h=%b want 1 %h %b", resp_valid, resp_data, hit, e.data, e.hit);
        end
    endtask

    task automatic test_plru();
        logic [31:0] addrs [11] = '{32'h1404, 32'h1808, 32'h1C0C, 32'h1000,
                                    32'h2004, 32'h1408, 32'h180C, 32'h1400,
                                    32'h1004, 32'h2008, 32'h1C00};
        logic hits [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                            1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] d; logic h; int lat; bit sm, to; exp_t e;
        for (int i = 0; i < 11; i++) begin
            exp_q.push_back('{mem_word(addrs[i]), hits[i]});
            fetch(addrs[i], d, h, lat, sm, to);
            e = exp_q.pop_front();
            n_vec++;
            if (to || d !== e.data) begin
                n_err++;
                $display("FAIL plru_data[%0d]: addr %h got %h want %h", i, addrs[i], d, e.data);
            end
            n_vec++;
            if (h !== e.hit) begin
                n_err++;
                $display("FAIL plru_hit[%0d]: addr %h got %b want %b", i, addrs[i], h, e.hit);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] d; logic h; int lat; bit sm, to; exp_t e; int rc;
        ready_delay = 5;
        beat_gap = 2;
        stable_err = 0;
        rc = req_count;
        exp_q.push_back('{mem_word(32'h2404), 1'b0});
        fetch(32'h2404, d, h, lat, sm, to);
        e = exp_q.pop_front();
        ready_delay = 0;
        beat_gap = 0;
        n_vec++;
        if (to || d !== e.data || h !== e.hit) begin
            n_err++;
            $display("FAIL stall_resp: got %h/%b want %h/%b", d, h, e.data, e.hit);
        end
        n_vec++;
        if (stable_err !== 0) begin n_err++; $display("FAIL stall_stable: got %0d unstable cycles want 0", stable_err); end
        n_vec++;
        if (req_log !== 32'h2400) begin n_err++; $display("FAIL stall_memaddr: got %h want 00002400", req_log); end
        n_vec++;
        if (lat !== 20) begin n_err++; $display("FAIL stall_latency: got %0d want 20", lat); end
        n_vec++;
        if (req_count - rc !== 1) begin n_err++; $display("FAIL stall_reqs: got %0d want 1", req_count - rc); end
    endtask

    task automatic test_flush();
        logic [31:0] d; logic h; int lat; bit sm, to; exp_t e;
        @(negedge clk);
        flush = 1'b1;
        req_valid = 1'b1;
        req_addr = 32'h1004;
        @(negedge clk);
        flush = 1'b0;
        req_valid = 1'b0;
        n_vec++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_noaccept: got rdy=%b v=%b want 1 0", req_ready, resp_valid);
        end
        exp_q.push_back('{32'hA1, 1'b0});
        fetch(32'h1004, d, h, lat, sm, to);
        e = exp_q.pop_front();
        n_vec++;
        if (to || d !== e.data || h !== e.hit || sm !== 1'b1) begin
            n_err++;
            $display("FAIL flush_miss: got %h/%b mem=%b want %h/%b mem=1", d, h, sm, e.data, e.hit);
        end
    endtask

    task automatic test_reset_midfill();
        logic [31:0] d; logic h; int lat; bit sm, to; exp_t e; bit seen;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        req_valid = 1'b1;
        req_addr = 32'h1004;
        @(negedge clk);
        req_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (beat_idx == 2) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        n_vec++;
        if (!seen) begin n_err++; $display("FAIL midfill_beat2: got no beat 2 want beat 2"); end
        reset = 1'b0;
        #1;
        n_vec++;
        if ({req_ready, resp_valid, hit, resp_data, mem_req_valid,
             mem_req_addr} !== {3'b100, 32'h0, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL midfill_reset_values: got rdy=%b rv=%b hit=%b d=%h mv=%b ma=%h want 1 0 0 0 0 0",
                     req_ready, resp_valid, hit, resp_data, mem_req_valid,
                     mem_req_addr);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        mem_resp_valid = 1'b0;
        n_vec++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stray_beats: got rdy=%b v=%b want 1 0", req_ready, resp_valid);
        end
        exp_q.push_back('{32'hA1, 1'b0});
        fetch(32'h1004, d, h, lat, sm, to);
        e = exp_q.pop_front();
        n_vec++;
        if (to || d !== e.data || h !== e.hit) begin
            n_err++;
            $display("FAIL midfill_refetch: got %h/%b want %h/%b", d, h, e.data, e.hit);
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_back_to_back();
        test_plru();
        test_stall();
        test_flush();
        test_reset_midfill();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
